uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, i_Clk cycles per serial bit (25 MHz / 115200); legal range >= 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of bytes buffered ahead of the shifter; power of two, >= 2.
REQ-003 SHALL have port i_Clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port i_Rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_TX_DV  input  1  byte-valid strobe; write request into the FIFO.
REQ-006 SHALL have port i_TX_Byte  input  8  byte to transmit, sampled when i_TX_DV is high.
REQ-007 SHALL have port o_TX_Ready  output  1  high when the FIFO is not full.
REQ-008 SHALL have port o_TX_Serial  output  1  serial line, idle high, registered.
REQ-009 SHALL have port o_TX_Active  output  1  high while a frame is on the line.
REQ-010 SHALL have port o_TX_Done  output  1  one-cycle pulse after each completed stop bit.

Function
REQ-011 SHALL accept a byte into the FIFO on any edge where i_TX_DV=1 and o_TX_Ready=1; bytes presented while o_TX_Ready=0 are dropped, with no FIFO state change.
REQ-012 SHALL derive o_TX_Ready combinationally as !full; a pop on the same edge does not make a write to a full FIFO accepted.
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only per REQ-027.
REQ-014 SHALL, in IDLE with FIFO non-empty, pop the head byte into an 8-bit shift register and enter START on that edge.
REQ-015 SHALL drive o_TX_Serial low for the first time on the second rising edge after the edge that writes a byte into an empty FIFO while in IDLE.
REQ-016 SHALL hold each of start, data, parity and stop bits for exactly CLKS_PER_BIT cycles, using a bit-period counter of width $clog2(CLKS_PER_BIT).
REQ-017 SHALL send data bits LSB first, bit 0 through bit 7, with a 3-bit bit index that wraps from 7 to exit DATA.
REQ-018 SHALL drive one stop bit of 1.
REQ-019 SHALL, at the end of STOP with the FIFO non-empty, pop and enter START directly, giving zero idle cycles between back-to-back frames; with the FIFO empty, it SHALL enter IDLE.
REQ-020 SHALL assert o_TX_Done for exactly the one cycle following the last stop-bit cycle, including in the back-to-back case.
REQ-021 SHALL assert o_TX_Active from the first start-bit cycle through the last stop-bit cycle, continuously across back-to-back frames.
REQ-022 SHALL keep o_TX_Serial=1 in IDLE.
REQ-023 SHALL not let i_TX_Byte changes after acceptance affect any queued or in-flight frame.

Reset
REQ-024 SHALL, on i_Rst=1, immediately (asynchronously) set: state=IDLE, o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, FIFO empty, o_TX_Ready=1, and all counters=0.
REQ-025 SHALL abort any in-flight frame on reset and discard all queued bytes; no partial frame resumes after reset release.
REQ-026 SHALL accept a write on the first rising edge after i_Rst deasserts.

Configuration
REQ-027 SHALL, with macro UART_TX_PARITY_EN defined, insert one PARITY bit between bit 7 and the stop bit, equal to the XOR of the 8 data bits (even parity), making the frame 11*CLKS_PER_BIT cycles.
REQ-028 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and logic, making the frame 10*CLKS_PER_BIT cycles.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 SHALL cover single byte: write 0xA5 in IDLE -> line low 2 edges later, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles, o_TX_Done pulse 40 cycles after start began.
REQ-030 SHALL cover back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles -> three frames with no idle gap, o_TX_Active high 120 cycles, three o_TX_Done pulses.
REQ-031 SHALL cover overflow: 6 consecutive writes 0x01..0x06 while frame 1 is active -> o_TX_Ready low after the FIFO fills, 0x06 dropped, exactly 0x01..0x05 transmitted.
REQ-032 SHALL cover reset mid-frame: assert i_Rst during DATA bit 3 of 0x3C with 2 bytes queued -> o_TX_Serial=1 immediately, no further frames, o_TX_Ready=1.
REQ-033 SHALL cover parity with UART_TX_PARITY_EN: 0x07 -> parity bit 1, 0x03 -> parity bit 0, frame 44 cycles.
REQ-034 SHALL cover simultaneous pop and write while full: write on the STOP->START edge with the FIFO full -> write dropped, o_TX_Ready rises the next cycle.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, 8N1 by default; define UART_TX_PARITY_EN for 8E1 framing.
// Rev 1.0
`default_nettype none

module uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_TX_Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       tx_shift;
  logic             bit_end;
  logic             stop_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  assign fifo_full  = (fifo_count == FIFO_FULL);
  assign fifo_empty = (fifo_count == '0);
  assign o_TX_Ready = !fifo_full;
  assign bit_end    = (bit_cnt == CNT_LAST);

  // Fullness is judged before any same-edge pop, so a write to a full FIFO is always dropped.
  assign push = i_TX_DV && !fifo_full;
  assign pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge i_Clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= i_TX_Byte;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The line outputs follow the state by one cycle, so the start bit appears
  // two edges after a write into an empty FIFO and Done lands just after the stop bit.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      tx_shift    <= '0;
      stop_end    <= 1'b0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      stop_end    <= (state == STOP) && bit_end;
      o_TX_Done   <= stop_end;
      o_TX_Active <= (state != IDLE);

      if ((state == IDLE) || bit_end) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (pop) begin
        tx_shift <= fifo_mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^fifo_mem[rd_ptr];
`endif
      end

      case (state)
        IDLE: begin
          o_TX_Serial <= 1'b1;
          bit_idx     <= '0;
          if (!fifo_empty) begin
            state <= START;
          end
        end
        START: begin
          o_TX_Serial <= 1'b0;
          if (bit_end) begin
            state <= DATA;
          end
        end
        DATA: begin
          o_TX_Serial <= tx_shift[0];
          if (bit_end) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          o_TX_Serial <= parity_bit;
          if (bit_end) begin
            state <= STOP;
          end
        end
`endif
        STOP: begin
          o_TX_Serial <= 1'b1;
          if (bit_end) begin
            state <= fifo_empty ? IDLE : START;
          end
        end
        default: begin
          o_TX_Serial <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Rev 1.0
`default_nettype none

module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       clk;
  logic       rst;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;

  int n_cmp;
  int n_err;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_TX_DV    (tx_dv),
    .i_TX_Byte  (tx_byte),
    .o_TX_Ready (tx_ready),
    .o_TX_Serial(tx_serial),
    .o_TX_Active(tx_active),
    .o_TX_Done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle before the start bit; returns in the last stop-bit cycle.
  // Each cycle compares {done, active, serial}.
  task automatic expect_frame(input logic [7:0] b, input logic done_first, input string tag);
    logic exp_ser;
    int   slot;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      slot = i / CPB;
      if (slot == 0)      exp_ser = 1'b0;
      else if (slot <= 8) exp_ser = b[slot-1];
`ifdef UART_TX_PARITY_EN
      else if (slot == 9) exp_ser = ^b;
`endif
      else                exp_ser = 1'b1;
      chk(tag, {29'd0, tx_done, tx_active, tx_serial},
          {29'd0, (done_first && (i == 0)), 1'b1, exp_ser});
    end
  endtask

  task automatic single_frame(input logic [7:0] b, input string tag);
    tx_dv   = 1'b1;
    tx_byte = b;
    tick();
    tx_dv   = 1'b0;
    tx_byte = ~b;
    chk({tag, "_ready"}, {31'd0, tx_ready}, 32'd1);
    tick();
    chk({tag, "_prestart"}, {29'd0, tx_done, tx_active, tx_serial}, 32'b001);
    expect_frame(b, 1'b0, tag);
    tick();
    chk({tag, "_done"}, {29'd0, tx_done, tx_active, tx_serial}, 32'b101);
    tick();
    chk({tag, "_idle"}, {29'd0, tx_done, tx_active, tx_serial}, 32'b001);
  endtask

  initial begin
    int bad;
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b0;
    tx_dv   = 1'b0;
    tx_byte = 8'h00;

    // Reset takes effect without a clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_outputs", {28'd0, tx_ready, tx_done, tx_active, tx_serial}, 32'b1001);
    tick();
    tick();

    // Single 0xA5 frame, written on the first edge after reset release.
    rst = 1'b0;
    single_frame(8'hA5, "a5");

    // Back-to-back 0x00, 0xFF, 0x55.
    tx_dv   = 1'b1;
    tx_byte = 8'h00;
    tick();
    tx_byte = 8'hFF;
    fork
      begin
        tick();
        expect_frame(8'h00, 1'b0, "b2b_00");
        expect_frame(8'hFF, 1'b1, "b2b_ff");
        expect_frame(8'h55, 1'b1, "b2b_55");
      end
      begin
        tick();
        tx_byte = 8'h55;
        tick();
        tx_dv   = 1'b0;
        tx_byte = 8'hEE;
      end
    join
    tick();
    chk("b2b_done", {29'd0, tx_done, tx_active, tx_serial}, 32'b101);
    tick();
    chk("b2b_idle", {29'd0, tx_done, tx_active, tx_serial}, 32'b001);

    // Overflow with 0x01..0x06, then a write on the STOP->START pop edge while full.
    tx_dv   = 1'b1;
    tx_byte = 8'h01;
    tick();
    tx_byte = 8'h02;
    fork
      begin
        tick();
        expect_frame(8'h01, 1'b0, "ovf_01");
        expect_frame(8'h02, 1'b1, "ovf_02");
        expect_frame(8'h03, 1'b1, "ovf_03");
        expect_frame(8'h04, 1'b1, "ovf_04");
        expect_frame(8'h05, 1'b1, "ovf_05");
      end
      begin
        tick();
        tx_byte = 8'h03;
        tick();
        tx_byte = 8'h04;
        tick();
        chk("ovf_ready_c3", {31'd0, tx_ready}, 32'd1);
        tx_byte = 8'h05;
        tick();
        chk("ovf_ready_full", {31'd0, tx_ready}, 32'd0);
        tx_byte = 8'h06;
        tick();
        tx_dv   = 1'b0;
        chk("ovf_ready_drop", {31'd0, tx_ready}, 32'd0);
        for (int k = 5; k < FRAME; k++) tick();
        chk("popwr_ready_before", {31'd0, tx_ready}, 32'd0);
        tx_dv   = 1'b1;
        tx_byte = 8'h77;
        tick();
        tx_dv   = 1'b0;
        chk("popwr_ready_after", {31'd0, tx_ready}, 32'd1);
      end
    join
    tick();
    chk("ovf_done", {29'd0, tx_done, tx_active, tx_serial}, 32'b101);
    bad = 0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      tick();
      if (!(tx_serial === 1'b1 && tx_active === 1'b0 && tx_done === 1'b0)) bad++;
    end
    chk("ovf_no_extra_frame", bad, 32'd0);

    // Reset during data bit 3 of 0x3C with two bytes queued.
    tx_dv   = 1'b1;
    tx_byte = 8'h3C;
    tick();
    tx_byte = 8'h11;
    tick();
    tx_byte = 8'h22;
    tick();
    tx_dv   = 1'b0;
    for (int k = 2; k < 18; k++) tick();
    chk("rst_mid_bit3_before", {30'd0, tx_active, tx_serial}, 32'b11);
    tick();
    chk("rst_mid_bit3_hold", {30'd0, tx_active, tx_serial}, 32'b11);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_async", {28'd0, tx_ready, tx_done, tx_active, tx_serial}, 32'b1001);
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      if (!(tx_serial === 1'b1 && tx_active === 1'b0 && tx_done === 1'b0)) bad++;
    end
    chk("rst_no_resume", bad, 32'd0);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);

`ifdef UART_TX_PARITY_EN
    single_frame(8'h07, "par_07");
    single_frame(8'h03, "par_03");
`else
    single_frame(8'h3C, "after_rst_3c");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
